oled_spi_receiver: RTL and testbench

OLED_SPI_RECEIVER -- requirements
Module: oled_spi_receiver

---
 rtl/oled_pkg.sv | 7 +
 rtl/spi_byte_rx.sv | 53 +++++
 rtl/oled_spi_receiver.sv | 108 ++++++++++
 tb/tb_oled_spi_receiver.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// oled_pkg: command codes and receiver state encoding shared by the OLED SPI receiver
package oled_pkg;
  localparam logic [7:0] C_CMD_COL = 8'h15;
  localparam logic [7:0] C_CMD_ROW = 8'h75;
  localparam logic [7:0] C_CMD_RAM = 8'h5C;
  typedef enum logic [2:0] {IDLE, COL_S, COL_E, ROW_S, ROW_E, RAM_WR, SKIP} state_t;
endpackage

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: synchronizes the SPI pins, detects the sampling edge and assembles MSB-first bytes
module spi_byte_rx #(
  parameter int c_clk_polarity = 1,
  parameter int c_clk_phase    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_csn,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_dc,
  output logic [7:0] o_byte,
  output logic       o_dc,
  output logic       o_strobe,
  output logic       o_csn
);
  logic [1:0] r_csn, r_mosi, r_dc;
  logic [2:0] r_sclk, r_cnt;
  logic [6:0] r_sr;
  logic       w_edge;
  assign w_edge = (c_clk_polarity == c_clk_phase) ? (r_sclk[1] & ~r_sclk[2]) : (~r_sclk[1] & r_sclk[2]);
  assign o_csn  = r_csn[1];
  // clock synchronizer resets to the idle level so leaving reset never fakes an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_csn    <= 2'b11;
      r_sclk   <= {3{1'(c_clk_polarity)}};
      r_mosi   <= '0;
      r_dc     <= '0;
      r_sr     <= '0;
      r_cnt    <= '0;
      o_byte   <= '0;
      o_dc     <= 1'b0;
      o_strobe <= 1'b0;
    end else begin
      r_csn    <= {r_csn[0], i_csn};
      r_sclk   <= {r_sclk[1:0], i_sclk};
      r_mosi   <= {r_mosi[0], i_mosi};
      r_dc     <= {r_dc[0], i_dc};
      o_strobe <= 1'b0;
      if (r_csn[1]) r_cnt <= '0;
      else if (w_edge) begin
        r_sr  <= {r_sr[5:0], r_mosi[1]};
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          o_byte   <= {r_sr, r_mosi[1]};
          o_dc     <= r_dc[1];
          o_strobe <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver: decodes OLED SPI command/data bytes into addressed pixel writes
// Define OLED_SPI_RECEIVER_CMD_OUT_EN to add the cmd_valid/cmd_byte command outputs
module oled_spi_receiver
  import oled_pkg::*;
#(
  parameter int c_color_bits   = 16,
  parameter int c_x_size       = 128,
  parameter int c_y_size       = 128,
  parameter int c_clk_polarity = 1,
  parameter int c_clk_phase    = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        spi_csn,
  input  logic                        spi_clk,
  input  logic                        spi_mosi,
  input  logic                        spi_dc,
`ifdef OLED_SPI_RECEIVER_CMD_OUT_EN
  output logic                        cmd_valid,
  output logic [7:0]                  cmd_byte,
`endif
  output logic                        px_valid,
  output logic [$clog2(c_x_size)-1:0] px_x,
  output logic [$clog2(c_y_size)-1:0] px_y,
  output logic [c_color_bits-1:0]     px_color
);
  localparam int XW = $clog2(c_x_size);
  localparam int YW = $clog2(c_y_size);
  logic [7:0]              w_byte, r_hi;
  logic                    w_dc, w_stb, w_csn, w_pix, r_have_hi;
  state_t                  r_state, w_state_nx;
  logic [XW-1:0]           r_col_s, r_col_e, r_x, w_col_e, w_xv;
  logic [YW-1:0]           r_row_s, r_row_e, r_y, w_row_e, w_yv;
  logic [c_color_bits-1:0] w_color;
  spi_byte_rx #(.c_clk_polarity(c_clk_polarity), .c_clk_phase(c_clk_phase)) u_rx (
    .clk(clk), .reset(reset), .i_csn(spi_csn), .i_sclk(spi_clk), .i_mosi(spi_mosi), .i_dc(spi_dc),
    .o_byte(w_byte), .o_dc(w_dc), .o_strobe(w_stb), .o_csn(w_csn)
  );
  // an inverted window collapses to the single line at its start
  always_comb begin
    w_col_e    = (r_col_e < r_col_s) ? r_col_s : r_col_e;
    w_row_e    = (r_row_e < r_row_s) ? r_row_s : r_row_e;
    w_xv       = (32'(w_byte) > c_x_size - 1) ? XW'(c_x_size - 1) : XW'(w_byte);
    w_yv       = (32'(w_byte) > c_y_size - 1) ? YW'(c_y_size - 1) : YW'(w_byte);
    w_pix      = w_stb & w_dc & (r_state == RAM_WR) & ((c_color_bits == 8) | r_have_hi);
    w_color    = c_color_bits'({r_hi, w_byte});
    w_state_nx = r_state;
    if (w_stb & ~w_dc)
      w_state_nx = (w_byte == C_CMD_COL) ? COL_S : (w_byte == C_CMD_ROW) ? ROW_S :
                   (w_byte == C_CMD_RAM) ? RAM_WR : SKIP;
    else if (w_stb)
      w_state_nx = (r_state == COL_S) ? COL_E : (r_state == ROW_S) ? ROW_E :
                   (r_state == COL_E || r_state == ROW_E) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      px_valid  <= 1'b0;
      px_x      <= '0;
      px_y      <= '0;
      px_color  <= '0;
      r_col_s   <= '0;
      r_col_e   <= XW'(c_x_size - 1);
      r_row_s   <= '0;
      r_row_e   <= YW'(c_y_size - 1);
      r_x       <= '0;
      r_y       <= '0;
      r_hi      <= '0;
      r_have_hi <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      px_valid <= w_pix;
      if (w_pix) begin
        px_x     <= r_x;
        px_y     <= r_y;
        px_color <= w_color;
        r_x      <= (r_x >= w_col_e) ? r_col_s : r_x + 1'b1;
        if (r_x >= w_col_e) r_y <= (r_y >= w_row_e) ? r_row_s : r_y + 1'b1;
      end
      if (w_stb & ~w_dc & (w_byte == C_CMD_RAM)) begin
        r_x <= r_col_s;
        r_y <= r_row_s;
      end
      if (w_stb & w_dc) begin
        if (r_state == COL_S) r_col_s <= w_xv;
        if (r_state == COL_E) r_col_e <= w_xv;
        if (r_state == ROW_S) r_row_s <= w_yv;
        if (r_state == ROW_E) r_row_e <= w_yv;
      end
      if (w_csn | (w_stb & ~w_dc)) r_have_hi <= 1'b0;
      else if (w_stb & w_dc & (r_state == RAM_WR) & (c_color_bits == 16)) begin
        r_have_hi <= ~r_have_hi;
        r_hi      <= w_byte;
      end
    end
  end
`ifdef OLED_SPI_RECEIVER_CMD_OUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_byte  <= '0;
    end else begin
      cmd_valid <= w_stb & ~w_dc;
      if (w_stb & ~w_dc) cmd_byte <= w_byte;
    end
  end
`endif
endmodule

// File: tb/tb_oled_spi_receiver.sv
// tb_oled_spi_receiver: drives all four SPI modes in parallel and checks pixels against a window model
module tb_oled_spi_receiver;
  logic clk = 1'b0, reset = 1'b1, csn = 1'b1, g = 1'b0, mosi = 1'b0, dc = 1'b0;
  logic        pv [4];
  logic [6:0]  px [4];
  logic [6:0]  py [4];
  logic [15:0] pc [4];
  logic [31:0] q0 [$], q1 [$], q2 [$], q3 [$], exp_q [$];
  int cyc = 0, edge_cyc = 0, last_px = 0, total = 0, bad = 0;
  string st;
  int cs, ce, rs, re, mx, my, hi;
  bit pend;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  oled_spi_receiver #(.c_clk_polarity(1), .c_clk_phase(0)) u0 (.clk(clk), .reset(reset), .spi_csn(csn),
    .spi_clk(~g), .spi_mosi(mosi), .spi_dc(dc), .px_valid(pv[0]), .px_x(px[0]), .px_y(py[0]), .px_color(pc[0]));
  oled_spi_receiver #(.c_clk_polarity(0), .c_clk_phase(0)) u1 (.clk(clk), .reset(reset), .spi_csn(csn),
    .spi_clk(g), .spi_mosi(mosi), .spi_dc(dc), .px_valid(pv[1]), .px_x(px[1]), .px_y(py[1]), .px_color(pc[1]));
  oled_spi_receiver #(.c_clk_polarity(1), .c_clk_phase(1)) u2 (.clk(clk), .reset(reset), .spi_csn(csn),
    .spi_clk(~g), .spi_mosi(mosi), .spi_dc(dc), .px_valid(pv[2]), .px_x(px[2]), .px_y(py[2]), .px_color(pc[2]));
  oled_spi_receiver #(.c_clk_polarity(0), .c_clk_phase(1)) u3 (.clk(clk), .reset(reset), .spi_csn(csn),
    .spi_clk(g), .spi_mosi(mosi), .spi_dc(dc), .px_valid(pv[3]), .px_x(px[3]), .px_y(py[3]), .px_color(pc[3]));
  always @(negedge clk) begin
    if (pv[0]) begin q0.push_back({2'b0, px[0], py[0], pc[0]}); last_px <= cyc; end
    if (pv[1]) q1.push_back({2'b0, px[1], py[1], pc[1]});
    if (pv[2]) q2.push_back({2'b0, px[2], py[2], pc[2]});
    if (pv[3]) q3.push_back({2'b0, px[3], py[3], pc[3]});
  end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  function automatic int qsize(input int k);
    return k == 0 ? q0.size() : k == 1 ? q1.size() : k == 2 ? q2.size() : q3.size();
  endfunction
  function automatic logic [31:0] getq(input int k, input int i);
    if (i >= qsize(k)) return 32'hFFFF_FFFF;
    return k == 0 ? q0[i] : k == 1 ? q1[i] : k == 2 ? q2[i] : q3[i];
  endfunction
  task automatic m_reset();
    st = "idle"; cs = 0; ce = 127; rs = 0; re = 127; mx = 0; my = 0; pend = 0;
  endtask
  function automatic int clip(input int v);
    return v > 127 ? 127 : v;
  endfunction
  // behavioural model: window registers, write cursor and pending high byte
  task automatic m_byte(input bit d, input int b);
    if (!d) begin
      pend = 0;
      st = b == 'h15 ? "col_s" : b == 'h75 ? "row_s" : b == 'h5C ? "ram" : "skip";
      if (st == "ram") begin mx = cs; my = rs; end
    end else if (st == "col_s") begin cs = clip(b); st = "col_e"; end
    else if (st == "col_e") begin ce = clip(b); st = "idle"; end
    else if (st == "row_s") begin rs = clip(b); st = "row_e"; end
    else if (st == "row_e") begin re = clip(b); st = "idle"; end
    else if (st == "ram") begin
      if (!pend) begin pend = 1; hi = b; end
      else begin
        pend = 0;
        exp_q.push_back({2'b0, 7'(mx), 7'(my), 8'(hi), 8'(b)});
        if (mx >= (ce > cs ? ce : cs)) begin
          mx = cs;
          my = (my >= (re > rs ? re : rs)) ? rs : my + 1;
        end else mx++;
      end
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input bit v, input bit d);
    mosi = v; dc = d; clks(1);
    g = 1'b1; edge_cyc = cyc; clks(2);
    g = 1'b0; clks(1);
  endtask
  task automatic send_byte(input bit d, input int b);
    for (int i = 7; i >= 0; i--) send_bit(b[i], d);
    m_byte(d, b);
  endtask
  task automatic win(input int c, input int a, input int b);
    send_byte(0, c); send_byte(1, a); send_byte(1, b);
  endtask
  task automatic pix(input int c);
    send_byte(1, (c >> 8) & 'hFF); send_byte(1, c & 'hFF);
  endtask
  task automatic cs_low();
    csn = 1'b0; clks(2);
  endtask
  task automatic cs_high();
    clks(2); csn = 1'b1; clks(3); pend = 0;
  endtask
  task automatic check_px(input string tag);
    clks(8);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s.count.u%0d", tag, k), 32'(qsize(k)), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
        chk($sformatf("%s.px%0d.u%0d", tag, i, k), getq(k, i), exp_q[i]);
    end
    q0.delete(); q1.delete(); q2.delete(); q3.delete(); exp_q.delete();
  endtask
  initial begin
    logic [31:0] w;
    logic [13:0] xy;
    int n;
    m_reset();
    clks(3); reset = 1'b0; clks(2);
    for (int k = 0; k < 4; k++) chk($sformatf("reset.u%0d", k), {1'b0, pv[k], px[k], py[k], pc[k]}, 32'h0);
    cs_low();
    win('h15, 0, 127); win('h75, 0, 127); send_byte(0, 'h5C); pix('hF800);
    clks(6);
    chk("latency", 32'(last_px - edge_cyc), 32'd4);
    chk("basic.u0", getq(0, 0), {2'b0, 7'd0, 7'd0, 16'hF800});
    check_px("basic");
    win('h15, 10, 11); win('h75, 5, 6); send_byte(0, 'h5C);
    for (int i = 0; i < 5; i++) pix($urandom_range(0, 'hFFFF));
    clks(8);
    for (int i = 0; i < 5; i++) begin
      w = getq(0, i); xy = w[29:16];
      chk($sformatf("window.xy%0d", i), {18'b0, xy}, {18'b0, 7'(10 + i % 2), 7'(5 + (i / 2) % 2)});
    end
    check_px("window");
    send_bit(1, 1); send_bit(0, 1); send_bit(1, 1); send_bit(1, 1);
    cs_high(); cs_low();
    send_byte(1, 'hAB);
    check_px("ab_only");
    send_byte(1, 'hCD);
    send_byte(1, 'h11); cs_high(); cs_low(); pix('h1234);
    check_px("csn");
    send_byte(0, 'hA0); send_byte(1, 'h74); send_byte(0, 'h5C); pix('h0F0F);
    check_px("skip");
    win('h15, 200, 3); send_byte(0, 'h5C);
    for (int i = 0; i < 3; i++) pix($urandom_range(0, 'hFFFF));
    check_px("clamp");
    pix('h5A5A);
    check_px("mode_5a");
    send_byte(1, 'h77);
    send_bit(1, 1); send_bit(1, 1); send_bit(0, 1); send_bit(1, 1);
    reset = 1'b1; clks(3); reset = 1'b0; m_reset(); clks(2);
    for (int k = 0; k < 4; k++) chk($sformatf("reset2.u%0d", k), {1'b0, pv[k], px[k], py[k], pc[k]}, 32'h0);
    win('h15, 2, 3); send_byte(0, 'h5C); pix('hC3A5); pix('h0001);
    check_px("midreset");
    for (int r = 0; r < 6; r++) begin
      win('h15, $urandom_range(0, 255), $urandom_range(0, 255));
      win('h75, $urandom_range(0, 255), $urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) begin send_byte(0, $urandom_range(0, 255)); send_byte(1, $urandom_range(0, 255)); end
      send_byte(0, 'h5C);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) pix($urandom_range(0, 'hFFFF));
      if ($urandom_range(0, 1) == 1) begin cs_high(); cs_low(); end
      check_px($sformatf("rand%0d", r));
    end
    cs_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
